alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational execute-stage ALU between N_REQ requesters, e.g. the main pipeline EXE stage and a multi-cycle helper unit.
- Arbitrates requests round-robin, drives the ALU operands and command, and captures the result into a single response register.
- Owns the architectural status register SR ({N,Z,C,V}, bit 3 down to 0) and updates it on flag-setting operations.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TAG_W, 4, width of the per-request tag returned with the response.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_cmd  in  4*N_REQ  EXE_CMD per requester; slice i is [4i+3:4i].
- req_val1  in  32*N_REQ  operand 1 per requester.
- req_val2  in  32*N_REQ  operand 2 per requester.
- req_s  in  N_REQ  update SR with this operation's flags.
- req_tag  in  TAG_W*N_REQ  opaque tag per requester.
- alu_cmd  out  4  to ALU EXE_CMD.
- alu_val1  out  32  to ALU Val1.
- alu_val2  out  32  to ALU Val2.
- alu_sr  out  4  to ALU SR; always equals the current SR register.
- alu_result  in  32  from ALU Result.
- alu_status  in  4  from ALU Status.
- rsp_valid  out  1  response register occupied.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  $clog2(N_REQ)  index of the winning requester.
- rsp_tag  out  TAG_W  tag of the winning request.
- rsp_result  out  32  captured ALU result.
- rsp_status  out  4  captured ALU status, captured even when req_s=0.
- sr  out  4  current status register.

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_id/rsp_tag/rsp_result/rsp_status=0, sr=4'b0000.
  - Round-robin pointer resets to requester 0; req_ready=0 while in reset.
- Grant:
  - can_issue = !rsp_valid || rsp_ready.
  - When can_issue is set, the arbiter picks the first asserted req_valid at or after the pointer, wrapping modulo N_REQ. req_ready is driven one-hot to the winner, combinationally in the same cycle.
  - No valid request or can_issue=0 -> req_ready all zero.
- ALU drive:
  - alu_cmd/val1/val2 are muxed from the winner's slices.
  - When there is no winner, they are muxed from the pointer's slice; this value is don't-care but must be deterministic and free of X.
- Capture, on the edge where req_valid[i]&&req_ready[i]:
  - rsp_* are loaded from the ALU outputs, and id/tag from requester i.
  - rsp_valid becomes 1.
  - The pointer moves to i+1 mod N_REQ.
  - Latency: accept at cycle T -> rsp_valid visible at T+1.
- Drain:
  - rsp_valid&&rsp_ready with no new accept -> rsp_valid=0.
  - Drain and accept in the same cycle -> the register is overwritten and rsp_valid stays 1, giving full throughput of one op per cycle.
- Backpressure: while rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable and no grant is issued.
- SR update:
  - On accept with req_s[i]=1, sr <= alu_status in the same edge.
  - The next granted op sees the new SR (needed for ADC/SBC chaining).
  - req_s=0 leaves sr unchanged.
- State machine for the response slot: EMPTY -> (accept) FULL; FULL -> (drain, no accept) EMPTY; FULL -> (drain+accept or hold) FULL.
- Requester rules:
  - A requester holds its req_* stable while valid and not ready. The arbiter does not check this.
  - Dropping req_valid before it is granted is legal; no state changes.
- Reset mid-operation: any held response is discarded, sr clears, and no response is emitted after rst_n rises until a new accept.

Optional Feature:
ALU_ARB_FIXED_PRIO_EN:
- Defined: fixed priority; the lowest-index valid requester always wins, and the pointer register is removed.
- Undefined: round-robin as above.

Decomposition:
- Package alu_arb_pkg:
  - EXE_CMD localparams: MOV=1, MVN=9, ADD=2, ADC=3, SUB=4, SBC=5, AND=6, ORR=7, EOR=8.
  - Status bit indices: SR_N=3, SR_Z=2, SR_C=1, SR_V=0.
  - Response struct typedef.
- Sub-module rr_arbiter (N, req, en -> one-hot gnt, pointer update on accept); the fixed-priority variant lives behind the macro inside it.

Test Plan:
- Reset: hold rst_n=0 with req_valid=2'b11 -> req_ready=0, rsp_valid=0, sr=0. Release -> the first grant goes to requester 0.
- Round-robin: both requesters valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 with one rsp per cycle and rsp_id matching.
- Backpressure: rsp_ready=0 for 3 cycles after the first accept -> req_ready=0 and the rsp_* outputs hold constant. Raising rsp_ready -> drain and a new accept occur in the same edge.
- SR chaining: req0 ADD with s=1, val1=0xFFFFFFFF, val2=1 -> rsp_result=0. The ALU drives C=1 and Z=1, and that alu_status is written to sr. The next req1 sees alu_sr equal to that value.
- req_s=0: an op with s=0 that produces a zero result -> rsp_status[SR_Z]=1 and sr unchanged.
- With ALU_ARB_FIXED_PRIO_EN defined: both requesters valid for 4 cycles -> requester 0 is granted every cycle and requester 1 never.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: EXE_CMD encodings, SR bit
// positions, the captured-response record and response-slot states.
package alu_arb_pkg;

  localparam logic [3:0] EXE_MOV = 4'd1;
  localparam logic [3:0] EXE_MVN = 4'd9;
  localparam logic [3:0] EXE_ADD = 4'd2;
  localparam logic [3:0] EXE_ADC = 4'd3;
  localparam logic [3:0] EXE_SUB = 4'd4;
  localparam logic [3:0] EXE_SBC = 4'd5;
  localparam logic [3:0] EXE_AND = 4'd6;
  localparam logic [3:0] EXE_ORR = 4'd7;
  localparam logic [3:0] EXE_EOR = 4'd8;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  status;
  } alu_out_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Flags only reach SR when the granted request asked for them.
  function automatic logic [3:0] next_sr(input logic [3:0] cur,
                                         input logic [3:0] status,
                                         input logic       upd);
    logic [3:0] nxt;
    if (upd) begin
      nxt = status;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters, the response consumer
// and the ALU share arbiter.
interface alu_share_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int TAG_W = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [4*N_REQ-1:0]     req_cmd;
  logic [32*N_REQ-1:0]    req_val1;
  logic [32*N_REQ-1:0]    req_val2;
  logic [N_REQ-1:0]       req_s;
  logic [TAG_W*N_REQ-1:0] req_tag;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [TAG_W-1:0]       rsp_tag;
  logic [31:0]            rsp_result;
  logic [3:0]             rsp_status;

  modport master (
    output req_valid, req_cmd, req_val1, req_val2, req_s, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_status
  );

  modport slave (
    input  req_valid, req_cmd, req_val1, req_val2, req_s, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_status
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin arbiter with pointer advance on grant. Build option
// ALU_ARB_FIXED_PRIO_EN turns it into a lowest-index-wins arbiter without a pointer.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 found,
  output logic [$clog2(N)-1:0] ptr
);
  localparam int PW = $clog2(N);

  logic hit_s;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign ptr = {PW{1'b0}};
`else
  logic [PW-1:0] ptr_r;

  // Pointer moves just past the requester that was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {PW{1'b0}};
    end else if (|gnt) begin
      ptr_r <= (gnt_idx == PW'(N - 1)) ? {PW{1'b0}} : gnt_idx + PW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;
`endif

  // Search requesters starting at the pointer, wrapping modulo N.
  always_comb begin
    int cand;
    gnt     = {N{1'b0}};
    gnt_idx = {PW{1'b0}};
    hit_s   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end else begin
        cand = cand;
      end
      if (!hit_s && req[cand]) begin
        hit_s   = 1'b1;
        gnt_idx = PW'(cand);
      end else begin
        hit_s = hit_s;
      end
    end
    if (en && hit_s) begin
      gnt[gnt_idx] = 1'b1;
    end else begin
      gnt = {N{1'b0}};
    end
    found = en && hit_s;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between N_REQ requesters, captures results in a
// single response slot and owns the NZCV status register. Option: ALU_ARB_FIXED_PRIO_EN.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic [3:0]          alu_cmd,
  output logic [31:0]         alu_val1,
  output logic [31:0]         alu_val2,
  output logic [3:0]          alu_sr,
  input  logic [31:0]         alu_result,
  input  logic [3:0]          alu_status,
  output logic [3:0]          sr
);
  localparam int ID_W = $clog2(N_REQ);
  localparam int CMD_W = 4;
  localparam int VAL_W = 32;

  logic [N_REQ-1:0] gnt_s;
  logic [ID_W-1:0]  win_idx_s;
  logic [ID_W-1:0]  ptr_s;
  logic [ID_W-1:0]  sel_idx_s;
  logic             found_s;
  logic             can_issue_s;
  logic             arb_en_s;
  logic             accept_s;

  slot_state_t      slot_r;
  alu_out_t         rsp_r;
  logic [ID_W-1:0]  rsp_id_r;
  logic [TAG_W-1:0] rsp_tag_r;
  logic [3:0]       sr_r;

  // Grants are suppressed while in reset so req_ready stays zero there.
  assign can_issue_s = (slot_r == SLOT_EMPTY) || bus.rsp_ready;
  assign arb_en_s    = can_issue_s && rst_n;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid),
    .en      (arb_en_s),
    .gnt     (gnt_s),
    .gnt_idx (win_idx_s),
    .found   (found_s),
    .ptr     (ptr_s)
  );

  assign bus.req_ready = gnt_s;
  assign accept_s      = |gnt_s;

  // Without a winner the pointer's slice feeds the ALU, keeping it X-free.
  assign sel_idx_s = found_s ? win_idx_s : ptr_s;
  assign alu_cmd   = bus.req_cmd[CMD_W*sel_idx_s +: CMD_W];
  assign alu_val1  = bus.req_val1[VAL_W*sel_idx_s +: VAL_W];
  assign alu_val2  = bus.req_val2[VAL_W*sel_idx_s +: VAL_W];
  assign alu_sr    = sr_r;

  // Response slot: state, captured payload and SR all move on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r    <= SLOT_EMPTY;
      rsp_r     <= '{result: 32'd0, status: 4'd0};
      rsp_id_r  <= {ID_W{1'b0}};
      rsp_tag_r <= {TAG_W{1'b0}};
      sr_r      <= 4'b0000;
    end else begin
      case (slot_r)
        SLOT_EMPTY: begin
          if (accept_s) begin
            slot_r <= SLOT_FULL;
          end else begin
            slot_r <= SLOT_EMPTY;
          end
        end
        SLOT_FULL: begin
          if (accept_s) begin
            slot_r <= SLOT_FULL;
          end else if (bus.rsp_ready) begin
            slot_r <= SLOT_EMPTY;
          end else begin
            slot_r <= SLOT_FULL;
          end
        end
        default: slot_r <= SLOT_EMPTY;
      endcase

      if (accept_s) begin
        rsp_r.result <= alu_result;
        rsp_r.status <= alu_status;
        rsp_id_r     <= win_idx_s;
        rsp_tag_r    <= bus.req_tag[TAG_W*win_idx_s +: TAG_W];
        sr_r         <= next_sr(sr_r, alu_status, bus.req_s[win_idx_s]);
      end else begin
        rsp_r     <= rsp_r;
        rsp_id_r  <= rsp_id_r;
        rsp_tag_r <= rsp_tag_r;
        sr_r      <= sr_r;
      end
    end
  end

  assign bus.rsp_valid  = (slot_r == SLOT_FULL);
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_tag    = rsp_tag_r;
  assign bus.rsp_result = rsp_r.result;
  assign bus.rsp_status = rsp_r.status;
  assign sr             = sr_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a behavioural ALU stub, a cycle model of
// grant/response/SR behaviour checked every cycle, plus hand-computed expectations.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int N  = 2;
  localparam int TW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_val1;
  logic [31:0] alu_val2;
  logic [3:0]  alu_sr;
  logic [31:0] alu_result;
  logic [3:0]  alu_status;
  logic [3:0]  sr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.N_REQ(N), .TAG_W(TW)) bus();

  alu_share_arbiter #(.N_REQ(N), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .alu_cmd    (alu_cmd),
    .alu_val1   (alu_val1),
    .alu_val2   (alu_val2),
    .alu_sr     (alu_sr),
    .alu_result (alu_result),
    .alu_status (alu_status),
    .sr         (sr)
  );

  // Reference ALU: returns {result, N, Z, C, V}; C on subtract means no borrow.
  function automatic logic [35:0] alu_fn(input logic [3:0] cmd, input logic [31:0] a,
                                         input logic [31:0] b, input logic [3:0] s);
    logic [32:0] t;
    logic [31:0] bo;
    logic        c;
    logic        v;
    logic        arith;
    t = 33'd0; bo = b; c = 1'b0; v = 1'b0; arith = 1'b0;
    case (cmd)
      EXE_MOV: t = {1'b0, b};
      EXE_MVN: t = {1'b0, ~b};
      EXE_ADD: begin t = {1'b0, a} + {1'b0, b}; arith = 1'b1; end
      EXE_ADC: begin t = {1'b0, a} + {1'b0, b} + {32'd0, s[SR_C]}; arith = 1'b1; end
      EXE_SUB: begin bo = ~b; t = {1'b0, a} + {1'b0, bo} + 33'd1; arith = 1'b1; end
      EXE_SBC: begin bo = ~b; t = {1'b0, a} + {1'b0, bo} + {32'd0, s[SR_C]}; arith = 1'b1; end
      EXE_AND: t = {1'b0, a & b};
      EXE_ORR: t = {1'b0, a | b};
      EXE_EOR: t = {1'b0, a ^ b};
      default: t = 33'd0;
    endcase
    if (arith) begin
      c = t[32];
      v = (a[31] == bo[31]) && (t[31] != a[31]);
    end
    return {t[31:0], t[31], (t[31:0] == 32'd0), c, v};
  endfunction

  always_comb {alu_result, alu_status} = alu_fn(alu_cmd, alu_val1, alu_val2, alu_sr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic s, input logic [TW-1:0] tag);
    bus.req_cmd[4*i +: 4]    = cmd;
    bus.req_val1[32*i +: 32] = a;
    bus.req_val2[32*i +: 32] = b;
    bus.req_s[i]             = s;
    bus.req_tag[TW*i +: TW]  = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model state: the response slot contents, SR and the round-robin pointer.
  int          m_ptr   = 0;
  bit          m_valid = 1'b0;
  int          m_id    = 0;
  logic [3:0]  m_tag   = 4'd0;
  logic [31:0] m_res   = 32'd0;
  logic [3:0]  m_stat  = 4'd0;
  logic [3:0]  m_sr    = 4'd0;

  // Compare on the falling edge, then advance the model to the post-edge state.
  always @(negedge clk) begin
    int          w;
    int          c;
    bit          can;
    logic [N-1:0] er;
    logic [35:0] o;
    if (!rst_n) begin
      chk("rst_req_ready", bus.req_ready, 32'd0);
      chk("rst_rsp_valid", bus.rsp_valid, 32'd0);
      chk("rst_sr", sr, 32'd0);
      m_ptr = 0; m_valid = 1'b0; m_sr = 4'd0;
    end else begin
      can = !m_valid || bus.rsp_ready;
      w = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (w < 0 && bus.req_valid[c]) w = c;
      end
      er = '0;
      if (can && w >= 0) er[w] = 1'b1;
      chk("req_ready", bus.req_ready, er);
      chk("alu_sr", alu_sr, m_sr);
      chk("sr", sr, m_sr);
      chk("rsp_valid", bus.rsp_valid, m_valid);
      if (m_valid) begin
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_tag", bus.rsp_tag, m_tag);
        chk("rsp_result", bus.rsp_result, m_res);
        chk("rsp_status", bus.rsp_status, m_stat);
      end
      if (er != '0) begin
        chk("alu_cmd", alu_cmd, bus.req_cmd[4*w +: 4]);
        chk("alu_val1", alu_val1, bus.req_val1[32*w +: 32]);
        chk("alu_val2", alu_val2, bus.req_val2[32*w +: 32]);
        o = alu_fn(bus.req_cmd[4*w +: 4], bus.req_val1[32*w +: 32], bus.req_val2[32*w +: 32], m_sr);
        m_res   = o[35:4];
        m_stat  = o[3:0];
        m_id    = w;
        m_tag   = bus.req_tag[TW*w +: TW];
        m_valid = 1'b1;
        if (bus.req_s[w]) m_sr = o[3:0];
`ifndef ALU_ARB_FIXED_PRIO_EN
        m_ptr = (w + 1) % N;
`endif
      end else if (bus.rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  logic [N-1:0] rr_seq [4];

  initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    rr_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    rr_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
    rst_n = 1'b0;
    bus.req_valid = '0; bus.rsp_ready = 1'b1;
    bus.req_cmd = '0; bus.req_val1 = '0; bus.req_val2 = '0; bus.req_s = '0; bus.req_tag = '0;

    // Reset with both requesters asking, then SR chaining ADD -> ADC.
    set_req(0, EXE_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, 4'h3);
    set_req(1, EXE_ADC, 32'd5, 32'd7, 1'b0, 4'h9);
    bus.req_valid = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("first_grant", bus.req_ready, 32'h1);
    step(); bus.req_valid = 2'b10;
    @(negedge clk);
    chk("add_result", bus.rsp_result, 32'd0);
    chk("add_sr", sr, 32'h6);
    chk("adc_sees_sr", alu_sr, 32'h6);
    chk("adc_grant", bus.req_ready, 32'h2);

    // Flag-free AND with a zero result.
    step(); set_req(0, EXE_AND, 32'h0000_00F0, 32'h0000_000F, 1'b0, 4'h5); bus.req_valid = 2'b01;
    @(negedge clk);
    chk("adc_result", bus.rsp_result, 32'd13);
    chk("adc_tag", bus.rsp_tag, 32'h9);
    step(); bus.req_valid = 2'b00;
    @(negedge clk);
    chk("and_z", bus.rsp_status[SR_Z], 32'd1);
    chk("and_sr_kept", sr, 32'h6);

    // Both requesters valid every cycle.
    step();
    set_req(0, EXE_MOV, 32'd0, 32'h0000_0011, 1'b0, 4'h1);
    set_req(1, EXE_EOR, 32'h0000_00A5, 32'h0000_000F, 1'b0, 4'h2);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("rr_grant", bus.req_ready, rr_seq[i]);
      step();
    end

    // Backpressure: hold for three cycles, then drain and accept together.
    bus.req_valid = 2'b00;
    step();
    set_req(0, EXE_MOV, 32'd0, 32'hDEAD_BEEF, 1'b0, 4'hA);
    set_req(1, EXE_EOR, 32'hFF00_FF00, 32'h00FF_00FF, 1'b0, 4'hB);
    bus.req_valid = 2'b01; bus.rsp_ready = 1'b0;
    @(negedge clk); chk("bp_accept", bus.req_ready, 32'h1);
    step(); bus.req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_no_grant", bus.req_ready, 32'h0);
      chk("bp_hold_result", bus.rsp_result, 32'hDEAD_BEEF);
      chk("bp_hold_tag", bus.rsp_tag, 32'hA);
      step();
    end
    bus.rsp_ready = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    @(negedge clk); chk("bp_release_grant", bus.req_ready, 32'h1);
    step(); bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
    @(negedge clk); chk("bp_release_result", bus.rsp_result, 32'hDEAD_BEEF);
`else
    @(negedge clk); chk("bp_release_grant", bus.req_ready, 32'h2);
    step(); bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
    @(negedge clk); chk("bp_release_result", bus.rsp_result, 32'hFFFF_FFFF);
`endif
    chk("bp_release_valid", bus.rsp_valid, 32'd1);

    // Reset while a response is held.
    step(); rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", bus.rsp_valid, 32'd0);
    chk("midrst_sr", sr, 32'd0);
    step(); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("post_rst_idle", bus.rsp_valid, 32'd0);
    end
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
